// File: rtl/mdio_pkg.sv
// Shared constants and state encoding for the Clause-22 MDIO management target.
// Field positions are relative to the 14-bit header and the 18-bit write tail.
package mdio_pkg;

  localparam logic [1:0] ST_CODE = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b01;
  localparam logic [1:0] OP_RD   = 2'b10;
  localparam logic [1:0] TA_WR   = 2'b10;

  localparam int unsigned HDR_ST_LSB  = 12;
  localparam int unsigned HDR_OP_LSB  = 10;
  localparam int unsigned HDR_PHY_LSB = 5;
  localparam int unsigned HDR_REG_LSB = 0;
  localparam int unsigned WSH_TA_LSB  = 16;

  // Bit-counter values, taken before the increment of the current rise.
  localparam logic [5:0] CNT_HDR_LAST   = 6'd13;
  localparam logic [5:0] CNT_TA_LAST    = 6'd15;
  localparam logic [5:0] CNT_FRAME_LAST = 6'd31;
  localparam logic [5:0] CNT_FRAME_END  = 6'd32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_WR,
    ST_RD_TA,
    ST_RD,
    ST_WAIT
  } state_e;

  function automatic logic op_valid(input logic [1:0] op);
    return (op == OP_WR) || (op == OP_RD);
  endfunction

endpackage

// File: rtl/mdc_edge_det.sv
// Edge detector for the slow MDC line, treated as a data input on clk.
// rise/fall are valid in the first clk cycle that sees the new MDC level.
module mdc_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic i_mdc,
  output logic o_rise,
  output logic o_fall
);

  logic r_mdc_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mdc_q <= 1'b0;
    end else begin
      r_mdc_q <= i_mdc;
    end
  end

  assign o_rise = i_mdc & ~r_mdc_q;
  assign o_fall = ~i_mdc & r_mdc_q;

endmodule

// File: rtl/mdio_receptor.sv
// PHY-side MDIO target: deserialises Clause-22 frames sampled on MDC rises, raises a
// write strobe for writes and serialises RD_DATA back on MDC falls for reads.
module mdio_receptor
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR = 5'd1,
  parameter bit         CHECK_TA = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MDC,
  input  logic        mdio_out,
  input  logic        mdio_oe,
  input  logic [15:0] RD_DATA,
  output logic        mdio_in,
  output logic        mdio_in_oe,
  output logic [4:0]  ADDR,
  output logic [15:0] WR_DATA,
  output logic        WR_STB,
  output logic        RD_REQ,
  output logic        frame_err
);

  logic w_rise;
  logic w_fall;

  mdc_edge_det u_edge (
    .clk    (clk),
    .rst    (rst),
    .i_mdc  (MDC),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  state_e      r_state;
  logic [5:0]  r_cnt;
  logic [12:0] r_hdr;
  logic [16:0] r_wsh;
  logic [15:0] r_rsh;

  logic [13:0] w_hdr_nxt;
  logic [17:0] w_wsh_nxt;
  logic [1:0]  w_st;
  logic [1:0]  w_op;
  logic [4:0]  w_phy;
  logic [4:0]  w_reg;
  logic        w_hdr_bad;
  logic        w_ta_bad;
  logic [5:0]  w_cnt_inc;

  // Shift registers viewed with the bit of the current rise already appended.
  always_comb begin
    w_hdr_nxt = {r_hdr, mdio_out};
    w_wsh_nxt = {r_wsh, mdio_out};
    w_st      = w_hdr_nxt[HDR_ST_LSB +: 2];
    w_op      = w_hdr_nxt[HDR_OP_LSB +: 2];
    w_phy     = w_hdr_nxt[HDR_PHY_LSB +: 5];
    w_reg     = w_hdr_nxt[HDR_REG_LSB +: 5];
    w_hdr_bad = (w_st != ST_CODE) || !op_valid(w_op);
    w_ta_bad  = CHECK_TA && (w_wsh_nxt[WSH_TA_LSB +: 2] != TA_WR);
    w_cnt_inc = r_cnt + 6'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 6'd0;
      r_hdr      <= '0;
      r_wsh      <= '0;
      r_rsh      <= '0;
      mdio_in    <= 1'b0;
      mdio_in_oe <= 1'b0;
      ADDR       <= '0;
      WR_DATA    <= '0;
      WR_STB     <= 1'b0;
      RD_REQ     <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      WR_STB    <= 1'b0;
      RD_REQ    <= 1'b0;
      frame_err <= 1'b0;

      unique case (r_state)
        ST_IDLE: begin
          if (w_rise && mdio_oe) begin
            r_hdr   <= {12'd0, mdio_out};
            r_cnt   <= 6'd1;
            r_state <= ST_HDR;
          end
        end

        ST_HDR: begin
          if (w_rise) begin
            r_hdr <= w_hdr_nxt[12:0];
            r_cnt <= w_cnt_inc;
            if (r_cnt == CNT_HDR_LAST) begin
              if (w_hdr_bad) begin
                frame_err <= 1'b1;
                r_state   <= ST_WAIT;
              end else if (w_phy != PHY_ADDR) begin
                r_state <= ST_WAIT;
              end else if (w_op == OP_WR) begin
                ADDR    <= w_reg;
                r_state <= ST_WR;
              end else begin
                ADDR    <= w_reg;
                RD_REQ  <= 1'b1;
                r_state <= ST_RD_TA;
              end
            end
          end
        end

        ST_WR: begin
          if (w_rise) begin
            if (!mdio_oe) begin
              frame_err <= 1'b1;
              r_state   <= ST_WAIT;
            end else begin
              r_wsh <= w_wsh_nxt[16:0];
              r_cnt <= w_cnt_inc;
              if (r_cnt == CNT_FRAME_LAST) begin
                if (w_ta_bad) begin
                  frame_err <= 1'b1;
                end else begin
                  WR_DATA <= w_wsh_nxt[15:0];
                  WR_STB  <= 1'b1;
                end
                r_cnt   <= 6'd0;
                r_state <= ST_IDLE;
              end
            end
          end
        end

        // First TA bit is left undriven; the second is driven low from the fall before it.
        ST_RD_TA: begin
          if (w_rise) begin
            r_cnt <= w_cnt_inc;
            if (r_cnt == CNT_TA_LAST) begin
              r_rsh   <= RD_DATA;
              r_state <= ST_RD;
            end
          end else if (w_fall && (r_cnt == CNT_TA_LAST)) begin
            mdio_in_oe <= 1'b1;
            mdio_in    <= 1'b0;
          end
        end

        ST_RD: begin
          if (w_rise) begin
            r_cnt <= w_cnt_inc;
          end else if (w_fall) begin
            if (r_cnt == CNT_FRAME_END) begin
              mdio_in_oe <= 1'b0;
              mdio_in    <= 1'b0;
              r_cnt      <= 6'd0;
              r_state    <= ST_IDLE;
            end else begin
              mdio_in <= r_rsh[15];
              r_rsh   <= {r_rsh[14:0], 1'b0};
            end
          end
        end

        ST_WAIT: begin
          if (w_rise && !mdio_oe) begin
            r_cnt   <= 6'd0;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_cnt   <= 6'd0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdio_receptor.sv
// Bench for mdio_receptor: drives generator-style MDIO frames and scores the strobes,
// read-back data and drive-enable timing against expectations queued with the stimulus.
module tb_mdio_receptor;

  localparam int HALF = 4;
  localparam int K_WR = 1;
  localparam int K_RD = 2;
  localparam int K_ERR = 3;

  typedef struct {
    int          kind;
    logic [4:0]  addr;
    logic [15:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        MDC;
  logic        mdio_out;
  logic        mdio_oe;
  logic [15:0] RD_DATA;
  logic        mdio_in;
  logic        mdio_in_oe;
  logic [4:0]  ADDR;
  logic [15:0] WR_DATA;
  logic        WR_STB;
  logic        RD_REQ;
  logic        frame_err;

  int   n_tests = 0;
  int   n_fail = 0;
  int   oe_cycles = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  int   mon_kind;

  mdio_receptor #(
    .PHY_ADDR (5'd1),
    .CHECK_TA (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .MDC        (MDC),
    .mdio_out   (mdio_out),
    .mdio_oe    (mdio_oe),
    .RD_DATA    (RD_DATA),
    .mdio_in    (mdio_in),
    .mdio_in_oe (mdio_in_oe),
    .ADDR       (ADDR),
    .WR_DATA    (WR_DATA),
    .WR_STB     (WR_STB),
    .RD_REQ     (RD_REQ),
    .frame_err  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_frame(input logic [1:0] op, input logic [4:0] phy,
                                           input logic [4:0] rg, input logic [1:0] ta,
                                           input logic [15:0] d);
    return {2'b01, op, phy, rg, ta, d};
  endfunction

  // One MDC period: data changes with the fall, mdio_in is captured at the rise.
  task automatic mdc_bit(input logic d, input logic oe, output logic cap);
    MDC      = 1'b0;
    mdio_out = d;
    mdio_oe  = oe;
    repeat (HALF) @(negedge clk);
    MDC = 1'b1;
    cap = mdio_in;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic send_frame(input logic [31:0] f, input int n_oe, input int n_bits,
                            output logic [31:0] cap);
    logic b;
    cap = '0;
    for (int i = 0; i < n_bits; i++) begin
      mdc_bit(f[31-i], (i < n_oe), b);
      cap = {cap[30:0], b};
    end
  endtask

  task automatic idle_bits(input int n);
    logic b;
    for (int i = 0; i < n; i++) mdc_bit(1'b1, 1'b0, b);
  endtask

  // Scoreboard: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (mdio_in_oe) oe_cycles++;
      if (WR_STB || RD_REQ || frame_err) begin
        mon_kind = WR_STB ? K_WR : (RD_REQ ? K_RD : K_ERR);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_pulse", mon_kind, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("pulse_kind", mon_kind, mon_e.kind);
          if (mon_kind == K_WR) begin
            check_eq("wr_addr", ADDR, mon_e.addr);
            check_eq("wr_data", WR_DATA, mon_e.data);
          end else if (mon_kind == K_RD) begin
            check_eq("rd_addr", ADDR, mon_e.addr);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] cap;
    rst      = 1'b1;
    MDC      = 1'b0;
    mdio_out = 1'b0;
    mdio_oe  = 1'b0;
    RD_DATA  = 16'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_mdio_in", mdio_in, 0);
    check_eq("rst_mdio_in_oe", mdio_in_oe, 0);
    check_eq("rst_addr", ADDR, 0);
    check_eq("rst_wr_data", WR_DATA, 0);
    check_eq("rst_pulses", {WR_STB, RD_REQ, frame_err}, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Plain write
    exp_q.push_back('{K_WR, 5'h0A, 16'hBEEF});
    oe_cycles = 0;
    send_frame(mk_frame(2'b01, 5'd1, 5'h0A, 2'b10, 16'hBEEF), 32, 32, cap);
    idle_bits(1);
    check_eq("wr_pending", exp_q.size(), 0);
    check_eq("wr_no_drive", oe_cycles, 0);

    // Plain read
    RD_DATA = 16'hA5C3;
    exp_q.push_back('{K_RD, 5'h03, 16'h0});
    oe_cycles = 0;
    send_frame(mk_frame(2'b10, 5'd1, 5'h03, 2'b11, 16'hFFFF), 14, 32, cap);
    idle_bits(1);
    check_eq("rd_capture", cap[16:0], {1'b0, 16'hA5C3});
    check_eq("rd_oe_cycles", oe_cycles, 17 * 2 * HALF);
    check_eq("rd_pending", exp_q.size(), 0);
    check_eq("rd_addr_held", ADDR, 5'h03);
    check_eq("wr_data_held", WR_DATA, 16'hBEEF);

    // PHY address mismatch is ignored
    oe_cycles = 0;
    send_frame(mk_frame(2'b01, 5'd2, 5'h0B, 2'b10, 16'h1234), 32, 32, cap);
    idle_bits(1);
    check_eq("mis_no_drive", oe_cycles, 0);
    check_eq("mis_wr_data", WR_DATA, 16'hBEEF);
    check_eq("mis_addr", ADDR, 5'h03);

    // Bad opcode, then a normal write
    exp_q.push_back('{K_ERR, 5'h0, 16'h0});
    send_frame(mk_frame(2'b11, 5'd1, 5'h04, 2'b10, 16'h5555), 32, 32, cap);
    idle_bits(1);
    check_eq("badop_pending", exp_q.size(), 0);
    exp_q.push_back('{K_WR, 5'h11, 16'h1357});
    send_frame(mk_frame(2'b01, 5'd1, 5'h11, 2'b10, 16'h1357), 32, 32, cap);
    idle_bits(1);
    check_eq("after_badop_pending", exp_q.size(), 0);

    // Generator releases the line after data bit 8
    exp_q.push_back('{K_ERR, 5'h0, 16'h0});
    send_frame(mk_frame(2'b01, 5'd1, 5'h05, 2'b10, 16'hCAFE), 24, 26, cap);
    check_eq("abort_pending", exp_q.size(), 0);
    check_eq("abort_wr_data", WR_DATA, 16'h1357);

    // Bad write turnaround
    exp_q.push_back('{K_ERR, 5'h0, 16'h0});
    send_frame(mk_frame(2'b01, 5'd1, 5'h06, 2'b00, 16'h2468), 32, 32, cap);
    idle_bits(1);
    check_eq("ta_pending", exp_q.size(), 0);
    check_eq("ta_wr_data", WR_DATA, 16'h1357);

    // Reset in the middle of a read's data phase
    RD_DATA = 16'h0F0F;
    exp_q.push_back('{K_RD, 5'h07, 16'h0});
    send_frame(mk_frame(2'b10, 5'd1, 5'h07, 2'b11, 16'hFFFF), 14, 20, cap);
    check_eq("rd_oe_before_rst", mdio_in_oe, 1);
    rst = 1'b1;
    @(negedge clk);
    check_eq("rst_mid_oe", mdio_in_oe, 0);
    check_eq("rst_mid_in", mdio_in, 0);
    check_eq("rst_mid_addr", ADDR, 0);
    rst = 1'b0;

    // Back-to-back write then read, no idle bit between
    exp_q.push_back('{K_WR, 5'h1C, 16'h9ABC});
    send_frame(mk_frame(2'b01, 5'd1, 5'h1C, 2'b10, 16'h9ABC), 32, 32, cap);
    RD_DATA = 16'h3C5A;
    exp_q.push_back('{K_RD, 5'h1C, 16'h0});
    oe_cycles = 0;
    send_frame(mk_frame(2'b10, 5'd1, 5'h1C, 2'b11, 16'hFFFF), 14, 32, cap);
    idle_bits(1);
    check_eq("b2b_capture", cap[16:0], {1'b0, 16'h3C5A});
    check_eq("b2b_oe_cycles", oe_cycles, 17 * 2 * HALF);
    check_eq("b2b_wr_data", WR_DATA, 16'h9ABC);
    check_eq("b2b_pending", exp_q.size(), 0);
    check_eq("b2b_oe_released", mdio_in_oe, 0);

    idle_bits(2);
    check_eq("final_pending", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
